image_box3x3: RTL and testbench

- Streaming 3x3 mean (box-blur) filter. Sits directly downstream of the image reader stage and upstream of the BMP writer.
- Consumes the reader's raster RGB888 stream, qualified by HSYNC, one pixel per clock.
- Emits a filtered stream of identical size and format, plus a frame-done pulse.
- Two on-chip line buffers per channel give the vertical neighbourhood; a 3x3 register window gives the horizontal one.

---
 rtl/image_box3x3_if.sv | 21 ++
 rtl/image_box3x3.sv | 180 ++++++++++++++++++
 tb/tb_image_box3x3.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/image_box3x3_if.sv
// rtl/image_box3x3_if.sv - RGB888 pixel stream bundle (input and filtered output) for image_box3x3
interface image_box3x3_if;
   logic       HSYNC_I;
   logic [7:0] DATA_R_I;
   logic [7:0] DATA_G_I;
   logic [7:0] DATA_B_I;
   logic       HSYNC_O;
   logic [7:0] DATA_R_O;
   logic [7:0] DATA_G_O;
   logic [7:0] DATA_B_O;

   modport master (
      output HSYNC_I, DATA_R_I, DATA_G_I, DATA_B_I,
      input  HSYNC_O, DATA_R_O, DATA_G_O, DATA_B_O
   );

   modport slave (
      input  HSYNC_I, DATA_R_I, DATA_G_I, DATA_B_I,
      output HSYNC_O, DATA_R_O, DATA_G_O, DATA_B_O
   );
endinterface

// File: rtl/image_box3x3.sv
// rtl/image_box3x3.sv - streaming 3x3 box-blur filter, RGB888, border pass-through
// Define IMAGE_BOX3X3_EDGE_REPLICATE_EN to filter borders with clamped coordinates instead.
module image_box3x3 #(
   parameter int WIDTH  = 768,
   parameter int HEIGHT = 512
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   image_box3x3_if.slave px,
   output logic          ctrl_done
);
   localparam int CW = $clog2(WIDTH);
   localparam int RW = $clog2(HEIGHT + 1);
   localparam int FW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] COL_LAST   = CW'(WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST   = RW'(HEIGHT - 1);
   localparam logic [RW-1:0] ROW_ONE    = RW'(1);
   localparam logic [FW-1:0] FLUSH_LAST = FW'(WIDTH);

   typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DONE} state_t;

   state_t state_q, state_d;
   logic [CW-1:0] in_col_q, in_col_d, out_col_q, out_col_d;
   logic [RW-1:0] in_row_q, in_row_d, out_row_q, out_row_d;
   logic [FW-1:0] flush_cnt_q, flush_cnt_d;
   // window columns, index [0]=top row, [1]=middle, [2]=bottom; win1 is the older column
   logic [2:0][23:0] win1_q, win1_d, win2_q, win2_d;
   logic          hsync_o_q, hsync_o_d;
   logic [23:0]   data_o_q, data_o_d;
   logic          ctrl_done_q, ctrl_done_d;

   logic [23:0] lb_a_mem [WIDTH];
   logic [23:0] lb_b_mem [WIDTH];

   logic             accept, step, emit, fill_done, last_in, flush_end;
   logic [23:0]      pix_in, lb_a_rd, lb_b_rd, centre, filt, result;
   logic [2:0][23:0] col_new;
   logic [2:0][2:0][23:0] tap;
   logic [11:0]      acc;

   assign pix_in    = {px.DATA_R_I, px.DATA_G_I, px.DATA_B_I};
   assign accept    = px.HSYNC_I && (state_q == IDLE || state_q == FILL || state_q == RUN);
   assign step      = accept || (state_q == FLUSH);
   assign emit      = (accept && state_q == RUN) || (state_q == FLUSH);
   assign fill_done = accept && (state_q == FILL) && (in_row_q == ROW_ONE) && (in_col_q == '0);
   assign last_in   = accept && (state_q == RUN) && (in_row_q == ROW_LAST) && (in_col_q == COL_LAST);
   assign flush_end = (state_q == FLUSH) && (flush_cnt_q == FLUSH_LAST);

   assign lb_a_rd = lb_a_mem[in_col_q];
   assign lb_b_rd = lb_b_mem[in_col_q];
   // during FLUSH the bottom tap lies below the image and is never used unclamped
   assign col_new = {accept ? pix_in : 24'd0, lb_a_rd, lb_b_rd};
   assign centre  = win2_q[1];

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q     <= IDLE;
         in_col_q    <= '0;
         in_row_q    <= '0;
         out_col_q   <= '0;
         out_row_q   <= '0;
         flush_cnt_q <= '0;
         win1_q      <= '0;
         win2_q      <= '0;
         hsync_o_q   <= 1'b0;
         data_o_q    <= '0;
         ctrl_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_col_q    <= in_col_d;
         in_row_q    <= in_row_d;
         out_col_q   <= out_col_d;
         out_row_q   <= out_row_d;
         flush_cnt_q <= flush_cnt_d;
         win1_q      <= win1_d;
         win2_q      <= win2_d;
         hsync_o_q   <= hsync_o_d;
         data_o_q    <= data_o_d;
         ctrl_done_q <= ctrl_done_d;
      end
   end

   // lb_a holds the previous row, lb_b the one before it
   always_ff @(posedge HCLK) begin
      if (accept) begin
         lb_b_mem[in_col_q] <= lb_a_rd;
         lb_a_mem[in_col_q] <= pix_in;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)    state_d = FILL;
         FILL:    if (fill_done) state_d = RUN;
         RUN:     if (last_in)   state_d = FLUSH;
         FLUSH:   if (flush_end) state_d = DONE;
         DONE:                   state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   always_comb begin
      tap[0] = win1_q;
      tap[1] = win2_q;
      tap[2] = col_new;
`ifdef IMAGE_BOX3X3_EDGE_REPLICATE_EN
      // rows first, then columns, so corners pick up the already-clamped rows
      for (int c = 0; c < 3; c++) begin
         if (out_row_q == '0)      tap[c][0] = tap[c][1];
         if (out_row_q == ROW_LAST) tap[c][2] = tap[c][1];
      end
      if (out_col_q == '0)      tap[0] = tap[1];
      if (out_col_q == COL_LAST) tap[2] = tap[1];
`endif
      filt = '0;
      acc  = '0;
      for (int ch = 0; ch < 3; ch++) begin
         acc = '0;
         for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 3; r++) begin
               acc = acc + 12'(tap[c][r][ch*8 +: 8]);
            end
         end
         filt[ch*8 +: 8] = 8'(acc / 12'd9);
      end
`ifdef IMAGE_BOX3X3_EDGE_REPLICATE_EN
      result = filt;
`else
      if (out_row_q == '0 || out_row_q == ROW_LAST || out_col_q == '0 || out_col_q == COL_LAST)
         result = centre;
      else
         result = filt;
`endif

      in_col_d    = in_col_q;
      in_row_d    = in_row_q;
      out_col_d   = out_col_q;
      out_row_d   = out_row_q;
      flush_cnt_d = '0;
      win1_d      = win1_q;
      win2_d      = win2_q;
      if (state_q == DONE) begin
         in_col_d  = '0;
         in_row_d  = '0;
         out_col_d = '0;
         out_row_d = '0;
      end else begin
         if (step) begin
            win1_d = win2_q;
            win2_d = col_new;
            if (in_col_q == COL_LAST) begin
               in_col_d = '0;
               in_row_d = in_row_q + 1'b1;
            end else begin
               in_col_d = in_col_q + 1'b1;
            end
         end
         if (emit) begin
            if (out_col_q == COL_LAST) begin
               out_col_d = '0;
               out_row_d = out_row_q + 1'b1;
            end else begin
               out_col_d = out_col_q + 1'b1;
            end
         end
         if (state_q == FLUSH) flush_cnt_d = flush_cnt_q + 1'b1;
      end

      hsync_o_d   = emit;
      data_o_d    = emit ? result : 24'd0;
      ctrl_done_d = (state_q == DONE);
   end

   assign px.HSYNC_O  = hsync_o_q;
   assign px.DATA_R_O = data_o_q[23:16];
   assign px.DATA_G_O = data_o_q[15:8];
   assign px.DATA_B_O = data_o_q[7:0];
   assign ctrl_done   = ctrl_done_q;
endmodule

// File: tb/tb_image_box3x3.sv
// tb/tb_image_box3x3.sv - self-checking bench for image_box3x3 at WIDTH=4, HEIGHT=3
module tb_image_box3x3;
   localparam int W = 4;
   localparam int H = 3;
   localparam int N = W * H;

   logic HCLK = 1'b0;
   logic HRESETn = 1'b1;
   logic ctrl_done;

   image_box3x3_if bif();

   image_box3x3 #(.WIDTH(W), .HEIGHT(H)) dut (
      .HCLK(HCLK),
      .HRESETn(HRESETn),
      .px(bif),
      .ctrl_done(ctrl_done)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      logic [23:0] pix;
      int          gap;
      logic [23:0] expv;
   } vec_t;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic [23:0] img [H][W];
   logic [23:0] cap_q [$];
   logic [23:0] exp_q [$];
   int first_in, first_out, last_out, done_cnt, done_cyc;
   vec_t vecs [6];

   task automatic check(input string name, input int got, input int expv);
      checks++;
      if (got !== expv) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, expv);
      end
   endtask

   initial forever begin
      @(posedge HCLK);
      cyc++;
   end

   initial forever begin
      @(negedge HCLK);
      if (HRESETn) begin
         if (bif.HSYNC_I && first_in < 0) first_in = cyc;
         if (bif.HSYNC_O) begin
            cap_q.push_back({bif.DATA_R_O, bif.DATA_G_O, bif.DATA_B_O});
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
         end else begin
            check("idle_data_zero", int'({bif.DATA_R_O, bif.DATA_G_O, bif.DATA_B_O}), 0);
         end
         if (ctrl_done) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   function automatic int clampi(input int v, input int hi);
      return (v < 0) ? 0 : ((v > hi) ? hi : v);
   endfunction

   // expected output pixel straight from the filter definition
   function automatic logic [23:0] ref_pix(input int r, input int c);
      logic [23:0] res;
      int sum;
      res = '0;
`ifndef IMAGE_BOX3X3_EDGE_REPLICATE_EN
      if (r == 0 || r == H-1 || c == 0 || c == W-1) return img[r][c];
`endif
      for (int ch = 0; ch < 3; ch++) begin
         sum = 0;
         for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
               sum += int'(img[clampi(r+dr, H-1)][clampi(c+dc, W-1)][ch*8 +: 8]);
         res[ch*8 +: 8] = 8'(sum / 9);
      end
      return res;
   endfunction

   task automatic clear_capture();
      cap_q.delete();
      exp_q.delete();
      first_in = -1;
      first_out = -1;
      last_out = -1;
      done_cnt = 0;
      done_cyc = -1;
   endtask

   task automatic drive_pix(input logic [23:0] p);
      @(posedge HCLK);
      #1;
      bif.HSYNC_I = 1'b1;
      {bif.DATA_R_I, bif.DATA_G_I, bif.DATA_B_I} = p;
   endtask

   task automatic drive_idle();
      @(posedge HCLK);
      #1;
      bif.HSYNC_I = 1'b0;
      {bif.DATA_R_I, bif.DATA_G_I, bif.DATA_B_I} = 24'($urandom);
   endtask

   task automatic send_frame(input int gap);
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            drive_pix(img[r][c]);
            if (gap == 1) drive_idle();
            if (gap == 2) repeat ($urandom_range(0, 2)) drive_idle();
         end
   endtask

   task automatic finish_frame(input int ndone, input int budget);
      drive_idle();
      for (int i = 0; i < budget && done_cnt < ndone; i++) drive_idle();
      check("done_within_budget", int'(done_cnt >= ndone), 1);
      repeat (W + 4) drive_idle();
      check("done_pulse_count", done_cnt, ndone);
   endtask

   task automatic compare_capture(input string name);
      int n;
      check({name, "_strobes"}, cap_q.size(), exp_q.size());
      n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
      for (int i = 0; i < n; i++)
         check($sformatf("%s_px%0d_r%0dc%0d", name, i, i / W, i % W), int'(cap_q[i]), int'(exp_q[i]));
   endtask

   task automatic model_push();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) exp_q.push_back(ref_pix(r, c));
   endtask

   task automatic load_impulse();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) img[r][c] = (r == 1 && c == 1) ? 24'hFF0000 : 24'h0;
   endtask

   // hand-derived: 255/9 = 28 wherever the (clamped) window covers (1,1)
   task automatic impulse_push();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
`ifdef IMAGE_BOX3X3_EDGE_REPLICATE_EN
            exp_q.push_back((c <= 2) ? 24'h1C0000 : 24'h0);
`else
            exp_q.push_back((r == 1 && (c == 1 || c == 2)) ? 24'h1C0000 : 24'h0);
`endif
         end
   endtask

   initial begin
      vecs[0] = '{pix: 24'h5A5A5A, gap: 0, expv: 24'h5A5A5A};
      vecs[1] = '{pix: 24'hFF0009, gap: 0, expv: 24'hFF0009};
      vecs[2] = '{pix: 24'hFF0009, gap: 1, expv: 24'hFF0009};
      vecs[3] = '{pix: 24'h000000, gap: 2, expv: 24'h000000};
      vecs[4] = '{pix: 24'hFFFFFF, gap: 0, expv: 24'hFFFFFF};
      vecs[5] = '{pix: 24'h25C879, gap: 1, expv: 24'h25C879};

      bif.HSYNC_I = 1'b0;
      {bif.DATA_R_I, bif.DATA_G_I, bif.DATA_B_I} = 24'h0;
      clear_capture();
      #2 HRESETn = 1'b0;
      repeat (3) @(posedge HCLK);
      #1;
      check("reset_hsync_o", int'(bif.HSYNC_O), 0);
      check("reset_data_o", int'({bif.DATA_R_O, bif.DATA_G_O, bif.DATA_B_O}), 0);
      check("reset_ctrl_done", int'(ctrl_done), 0);
      HRESETn = 1'b1;
      repeat (2) drive_idle();

      for (int v = 0; v < 6; v++) begin
         clear_capture();
         for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = vecs[v].pix;
         for (int i = 0; i < N; i++) exp_q.push_back(vecs[v].expv);
         send_frame(vecs[v].gap);
         finish_frame(1, 200);
         compare_capture($sformatf("const%0d", v));
         if (vecs[v].gap == 0) check($sformatf("const%0d_first_latency", v), first_out - first_in, W + 2);
         check($sformatf("const%0d_done_after_last", v), done_cyc - last_out, 1);
      end

      for (int g = 0; g < 2; g++) begin
         clear_capture();
         load_impulse();
         impulse_push();
         send_frame(g);
         finish_frame(1, 200);
         compare_capture($sformatf("impulse_gap%0d", g));
         check($sformatf("impulse_gap%0d_done_after_last", g), done_cyc - last_out, 1);
      end

      clear_capture();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) img[r][c] = 24'h323232;
      for (int i = 0; i < 7; i++) drive_pix(img[i / W][i % W]);
      @(posedge HCLK);
      #1;
      bif.HSYNC_I = 1'b0;
      HRESETn = 1'b0;
      #1;
      check("midrst_strobes_before", cap_q.size(), 1);
      check("midrst_hsync_o", int'(bif.HSYNC_O), 0);
      check("midrst_data_o", int'({bif.DATA_R_O, bif.DATA_G_O, bif.DATA_B_O}), 0);
      repeat (3) @(posedge HCLK);
      #1;
      HRESETn = 1'b1;
      repeat (W + 8) drive_idle();
      check("midrst_no_done", done_cnt, 0);
      clear_capture();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) img[r][c] = 24'h5A5A5A;
      model_push();
      send_frame(0);
      finish_frame(1, 200);
      compare_capture("after_midrst");

      // back-to-back at the minimum gap, with junk pixels offered during FLUSH
      clear_capture();
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) img[r][c] = 24'($urandom);
      model_push();
      send_frame(0);
      for (int i = 0; i < W + 1; i++) drive_pix(24'($urandom));
      repeat (2) drive_idle();
      load_impulse();
      impulse_push();
      send_frame(0);
      finish_frame(2, 400);
      compare_capture("b2b");

      for (int f = 0; f < 4; f++) begin
         clear_capture();
         for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = 24'($urandom);
         model_push();
         send_frame(int'($urandom_range(0, 2)));
         finish_frame(1, 300);
         compare_capture($sformatf("rand%0d", f));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
